zigzag_scan_reader: RTL and testbench

ZIGZAG_SCAN_READER -- requirements
Module: zigzag_scan_reader

---
 rtl/zigzag_pkg.sv | 16 +
 rtl/zigzag_walker.sv | 53 +++++
 rtl/zigzag_scan_reader.sv | 103 ++++++++++
 tb/tb_zigzag_scan_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zigzag_pkg.sv
// Shared types and constants for the 8x8 zigzag scan reader.
package zigzag_pkg;

   localparam int BLOCK_N = 64;

   typedef enum logic {
      FILL  = 1'b0,
      DRAIN = 1'b1
   } state_t;

   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } coord_t;

endpackage

// File: rtl/zigzag_walker.sv
// Steps (row, col) through the JPEG zigzag order, one position per i_step.
module zigzag_walker
   import zigzag_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_clear,
   input  logic       i_step,
   output logic [2:0] o_row,
   output logic [2:0] o_col
);

   logic [2:0] r_row;
   logic [2:0] r_col;
   logic       r_up;

   // Edge checks on the far side (col 7 / row 7) win over the near-side checks.
   always_ff @(posedge i_clk) begin
      if (i_reset || i_clear) begin
         r_row <= 3'd0;
         r_col <= 3'd0;
         r_up  <= 1'b1;
      end else if (i_step) begin
         if (r_up) begin
            if (r_col == 3'd7) begin
               r_row <= r_row + 3'd1;
               r_up  <= 1'b0;
            end else if (r_row == 3'd0) begin
               r_col <= r_col + 3'd1;
               r_up  <= 1'b0;
            end else begin
               r_row <= r_row - 3'd1;
               r_col <= r_col + 3'd1;
            end
         end else begin
            if (r_row == 3'd7) begin
               r_col <= r_col + 3'd1;
               r_up  <= 1'b1;
            end else if (r_col == 3'd0) begin
               r_row <= r_row + 3'd1;
               r_up  <= 1'b1;
            end else begin
               r_row <= r_row + 3'd1;
               r_col <= r_col - 3'd1;
            end
         end
      end
   end

   assign o_row = r_row;
   assign o_col = r_col;

endmodule

// File: rtl/zigzag_scan_reader.sv
// Buffers one 8x8 block in raster order, then replays it in zigzag order.
// state | meaning
// FILL  | accepting raster coefficients into mem
// DRAIN | emitting mem in zigzag order, input stalled
module zigzag_scan_reader
   import zigzag_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [DATA_W-1:0] i_in_data,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   output logic [DATA_W-1:0] o_out_data,
   output logic [5:0]        o_out_pos,
   output logic [5:0]        o_out_index,
   output logic              o_out_last,
   output logic              o_out_valid,
   input  logic              i_out_ready
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [5:0]        r_wr_cnt;
   logic [6:0]        r_rd_cnt;
   logic [DATA_W-1:0] r_mem [BLOCK_N];
   logic [DATA_W-1:0] r_out_data;
   logic [5:0]        r_out_pos;
   logic [5:0]        r_out_index;
   logic              r_out_last;
   logic              r_out_valid;

   coord_t            w_coord;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_last_xfer;
   logic              w_load;

   assign w_in_xfer   = (r_state == FILL) && i_in_valid;
   assign w_out_xfer  = r_out_valid && i_out_ready;
   assign w_last_xfer = w_out_xfer && r_out_last;
   assign w_load      = (r_state == DRAIN) && (!r_out_valid || i_out_ready)
                        && (r_rd_cnt < 7'(BLOCK_N));

   zigzag_walker u_walker (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (w_last_xfer),
      .i_step  (w_load),
      .o_row   (w_coord.row),
      .o_col   (w_coord.col)
   );

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         FILL:    if (w_in_xfer && (r_wr_cnt == 6'(BLOCK_N - 1))) w_state_nxt = DRAIN;
         DRAIN:   if (w_last_xfer) w_state_nxt = FILL;
         default: w_state_nxt = FILL;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= FILL;
         r_wr_cnt    <= 6'd0;
         r_rd_cnt    <= 7'd0;
         r_out_data  <= '0;
         r_out_pos   <= 6'd0;
         r_out_index <= 6'd0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_xfer) r_wr_cnt <= r_wr_cnt + 6'd1;
         if (w_last_xfer)  r_rd_cnt <= 7'd0;
         else if (w_load)  r_rd_cnt <= r_rd_cnt + 7'd1;
         if (w_load) begin
            r_out_data  <= r_mem[w_coord];
            r_out_pos   <= w_coord;
            r_out_index <= r_rd_cnt[5:0];
            r_out_last  <= (r_rd_cnt == 7'(BLOCK_N - 1));
            r_out_valid <= 1'b1;
         end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   // Storage is deliberately not reset; a reset just discards the partial block.
   always_ff @(posedge i_clk) begin
      if (w_in_xfer) r_mem[r_wr_cnt] <= i_in_data;
   end

   assign o_in_ready  = (r_state == FILL);
   assign o_out_data  = r_out_data;
   assign o_out_pos   = r_out_pos;
   assign o_out_index = r_out_index;
   assign o_out_last  = r_out_last;
   assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_zigzag_scan_reader.sv
// Self-checking bench: queue-based block model plus spot-check tables.
module tb_zigzag_scan_reader;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] out_data;
   logic [5:0]    out_pos;
   logic [5:0]    out_index;
   logic          out_last;
   logic          out_valid;
   logic          out_ready;

   always #5 clk = ~clk;

   zigzag_scan_reader #(.DATA_W(DW)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_in_data   (in_data),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .o_out_data  (out_data),
      .o_out_pos   (out_pos),
      .o_out_index (out_index),
      .o_out_last  (out_last),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [5:0]    pos;
      logic [5:0]    idx;
      logic          last;
   } out_t;

   typedef struct {
      int idx;
      int data;
      int pos;
   } vec_t;

   int            total = 0;
   int            bad = 0;
   int            zz [64];
   int            got [64];
   out_t          avail [$];
   logic [DW-1:0] blk [$];
   bit            m_fill;
   bit            m_valid;
   out_t          m_out;
   int            blocks_done = 0;
   vec_t          tbl [14];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Zigzag order from diagonals: odd diagonals run with row rising, even with row falling.
   function automatic void build_zz();
      int n = 0;
      for (int s = 0; s <= 14; s++) begin
         for (int k = 0; k < 8; k++) begin
            int r = (s % 2 == 1) ? k : 7 - k;
            int c = s - r;
            if (c >= 0 && c <= 7) begin
               zz[n] = r * 8 + c;
               n++;
            end
         end
      end
   endfunction

   task automatic model_reset();
      m_fill  = 1'b1;
      m_valid = 1'b0;
      m_out   = '0;
      avail.delete();
      blk.delete();
   endtask

   task automatic model_edge(input bit iv, input logic [DW-1:0] id, input bit orr);
      bit   oxfer, lastx, load;
      out_t t;
      oxfer = m_valid && orr;
      lastx = oxfer && m_out.last;
      load  = (!m_valid || orr) && (avail.size() > 0);
      if (load) begin
         m_out   = avail.pop_front();
         m_valid = 1'b1;
      end else if (oxfer) begin
         m_valid = 1'b0;
      end
      if (m_fill && iv) begin
         blk.push_back(id);
         if (blk.size() == 64) begin
            m_fill = 1'b0;
            for (int i = 0; i < 64; i++) begin
               t.data = blk[zz[i]];
               t.pos  = 6'(zz[i]);
               t.idx  = 6'(i);
               t.last = (i == 63);
               avail.push_back(t);
            end
            blk.delete();
         end
      end
      if (lastx) begin
         m_fill = 1'b1;
         blocks_done++;
      end
   endtask

   task automatic check_outputs();
      chk("in_ready", int'(in_ready), int'(m_fill));
      chk("out_valid", int'(out_valid), int'(m_valid));
      chk("out_data", int'(out_data), int'(m_out.data));
      chk("out_pos", int'(out_pos), int'(m_out.pos));
      chk("out_index", int'(out_index), int'(m_out.idx));
      chk("out_last", int'(out_last), int'(m_out.last));
      if (out_valid === 1'b1) got[out_index] = int'(out_data);
   endtask

   // Drive one cycle's inputs, advance the model over the coming edge, compare afterwards.
   task automatic tick(input bit iv, input logic [DW-1:0] id, input bit orr, input bit rs);
      rst       = rs;
      in_valid  = iv;
      in_data   = id;
      out_ready = orr;
      if (rs) model_reset();
      else    model_edge(iv, id, orr);
      @(negedge clk);
      check_outputs();
   endtask

   task automatic clear_got();
      for (int i = 0; i < 64; i++) got[i] = -1;
   endtask

   task automatic check_table(input string tag);
      for (int i = 0; i < 14; i++) begin
         chk({tag, "_data"}, got[tbl[i].idx], tbl[i].data);
      end
   endtask

   // vmode: 0 valid always, 1 toggle, 2 random; rmode: 0 ready always, 1 random, 2 stall at index 9.
   task automatic run(input int nblk, input int vmode, input int rmode, input int reset_at);
      int            sent = 0;
      int            stall = 0;
      bit            stalled = 0;
      bit            resume = 0;
      int            start = blocks_done;
      int            n = 0;
      bit            iv, orr;
      logic [DW-1:0] d;
      while (blocks_done < start + nblk && n < 3000) begin
         iv  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (n[0] == 1'b0) : 1'($urandom_range(0, 1));
         d   = (vmode == 2) ? DW'($urandom) : DW'((sent % 64) + 100 * (sent / 64));
         orr = (rmode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
         if (rmode == 2 && !stalled && out_valid === 1'b1 && out_index == 6'd9) begin
            stall   = 5;
            stalled = 1'b1;
         end
         if (stall > 0) orr = 1'b0;
         if (reset_at >= 0 && out_valid === 1'b1 && int'(out_index) == reset_at) begin
            tick(1'b0, '0, 1'b0, 1'b1);
            return;
         end
         if (m_fill && iv) sent++;
         tick(iv, d, orr, 1'b0);
         if (resume) begin
            chk("resume_index", int'(out_index), 10);
            chk("resume_data", int'(out_data), 32);
            resume = 1'b0;
         end
         if (stall > 0) begin
            chk("stall_data", int'(out_data), 24);
            chk("stall_pos", int'(out_pos), 24);
            stall--;
            if (stall == 0) resume = 1'b1;
         end
         n++;
      end
      if (n >= 3000) chk("run_timeout", n, 0);
   endtask

   initial begin
      tbl[0]  = '{0, 0, 0};    tbl[1]  = '{1, 1, 1};    tbl[2]  = '{2, 8, 8};
      tbl[3]  = '{3, 16, 16};  tbl[4]  = '{4, 9, 9};    tbl[5]  = '{5, 2, 2};
      tbl[6]  = '{6, 3, 3};    tbl[7]  = '{7, 10, 10};  tbl[8]  = '{8, 17, 17};
      tbl[9]  = '{9, 24, 24};  tbl[10] = '{10, 32, 32}; tbl[11] = '{61, 55, 55};
      tbl[12] = '{62, 62, 62}; tbl[13] = '{63, 63, 63};
      build_zz();
      clear_got();

      tick(1'b0, '0, 1'b0, 1'b1);
      tick(1'b1, 16'h5555, 1'b0, 1'b1);
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);

      run(1, 0, 0, -1);
      check_table("stream");
      chk("stream_last_pos", int'(out_pos), 63);

      run(1, 0, 2, -1);

      clear_got();
      run(1, 1, 0, -1);
      check_table("toggle");

      run(1, 0, 0, 20);
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_in_ready", int'(in_ready), 1);
      clear_got();
      run(1, 0, 0, -1);
      check_table("fresh");

      clear_got();
      run(2, 0, 0, -1);
      chk("b2b_idx0", got[0], 100);
      chk("b2b_idx1", got[1], 101);
      chk("b2b_idx2", got[2], 108);
      chk("b2b_idx63", got[63], 163);

      run(3, 2, 1, -1);
      tick(1'b0, '0, 1'b1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
